crc_stream_checker: RTL and testbench
=====================================

# crc_stream_checker

Multi-beat, parametrised CRC checker for streaming packets, generalising the single-beat 512-bit CRC32 detector. It accumulates a CRC of configurable width and polynomial over packets of 1..MAX_BEATS beats of DATA_WIDTH bits and compares it with the checksum carried on the last beat. It sits between a link receiver and the packet buffer, forwards data with one register stage and valid/ready backpressure, and flags corrupted or over-long packets on their last output beat.

## Interface
- DATA_WIDTH, 512, bits per beat
- CRC_WIDTH, 32, CRC register width, 1..64
- POLY, 32'h04C1_1DB7, generator polynomial, implicit x^CRC_WIDTH term omitted
- INIT, '0, CRC register value at the start of each packet; no reflection, no final XOR
- MAX_BEATS, 64, maximum legal beats per packet, 1 or more
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- valid_i  in  1  input beat valid
- ready_o  out  1  input beat accepted when valid_i && ready_o
- data_i  in  DATA_WIDTH  beat data
- last_i  in  1  last beat of packet
- checksum_i  in  CRC_WIDTH  received CRC; sampled only on the last beat
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream ready
- data_o  out  DATA_WIDTH  registered data
- last_o  out  1  registered last
- detected_o  out  1  CRC mismatch or overrun; meaningful only when last_o=1, otherwise 0
- overrun_o  out  1  packet exceeded MAX_BEATS; qualified like detected_o
- err_cnt_o  out  16  count of flagged packets; see Configuration

## Operation
- Per accepted beat: crc <= step(crc, data_i), where data is shifted in MSB-first (bit DATA_WIDTH-1 first), equivalent to DATA_WIDTH serial LFSR steps.
- On accepted last beat, final = step(crc, data_i), detected = (final != checksum_i), and crc <= INIT.
- States:
  - IDLE: no packet in progress.
  - BUSY: mid-packet.
  - DISCARD: dropping an over-long packet.
- Transitions:
  - IDLE -> BUSY on an accepted non-last beat; an accepted last beat stays IDLE (single-beat packet).
  - BUSY -> IDLE on an accepted last beat.
  - BUSY -> DISCARD when the accepted beat is beat number MAX_BEATS and last_i=0. That beat is emitted with last_o=1, detected_o=1 and overrun_o=1.
  - DISCARD: ready_o=1; beats are accepted and dropped, never forwarded. The accepted last_i beat returns to IDLE with crc=INIT.
- Beat counter: width $clog2(MAX_BEATS+1). Cleared on last or overrun.
- MAX_BEATS=1 with last_i=0 on the first beat: overrun on that beat.
- Back-to-back packets: the beat after a last beat starts from INIT with no bubble.

## Timing
- Reset values:
  - Outputs: valid_o=0, data_o=0, last_o=0, detected_o=0, overrun_o=0, err_cnt_o=0.
  - Internal: state=IDLE, crc=INIT, beat counter=0.
- Reset mid-packet abandons the packet. The first accepted beat after reset starts a new packet.
- Latency: one cycle from input handshake to valid_o.
- ready_o = !valid_o || ready_i, except ready_o=1 in DISCARD.
- While valid_o && !ready_i, all outputs hold stable.
- Full throughput: one beat per cycle when ready_i=1.
- All CRC arithmetic completes in the accept cycle; there is no internal pipeline beyond the output register.

## Configuration
- CRC_ERR_CNT_EN defined: err_cnt_o increments when a beat with last_o=1 and detected_o=1 is accepted downstream (valid_o && ready_i). It saturates at 16'hFFFF and is cleared only by reset.
- CRC_ERR_CNT_EN undefined: err_cnt_o is tied to 0 and the counter logic is absent.

## Structure
- Package crc_pkg holds:
  - the state enum (IDLE, BUSY, DISCARD);
  - function crc_step(crc, data, poly), elaboration-safe, MSB-first.
- Sub-module crc_update (combinational, parameters DATA_WIDTH/CRC_WIDTH/POLY) wraps crc_step. It is reusable by the matching generator block.

## Test plan
- CRC-8 config (DATA_WIDTH=8, CRC_WIDTH=8, POLY=8'h07, INIT=0):
  - Packet "123456789" (9 beats, 8'h31..8'h39) with checksum 8'hF4 -> 9 output beats, last_o on the 9th, detected_o=0.
  - Same packet with checksum 8'hF5 -> detected_o=1 on the 9th beat only; err_cnt_o=1 with the macro, 0 without.
- Single-beat packet 8'h01 with checksum 8'h07 -> detected_o=0, latency 1 cycle. An immediate second single-beat packet 8'h01 with checksum 8'h07 also passes, confirming INIT reload.
- MAX_BEATS=4 with a 6-beat packet -> 4 output beats; the 4th has last_o=1, detected_o=1, overrun_o=1. Beats 5-6 are dropped with ready_o=1. The next packet checks normally.
- Backpressure: ready_i low for 3 cycles mid-packet -> outputs held stable, ready_o=0, no beat lost or duplicated, CRC result unchanged.
- Reset: assert rst_n=0 after 3 beats of a packet -> all outputs reset. A fresh valid packet then checks with detected_o=0.

Source files
------------

// File: rtl/crc_pkg.sv
// crc_pkg: shared definitions for the streaming CRC checker and generator.
// Holds the packet state encoding and a bit-serial, MSB-first CRC step that
// is safe to evaluate at elaboration time as well as in combinational logic.
// Widths up to CRC_MAX_WIDTH (CRC register) and CRC_MAX_DATA (beat) bits.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  localparam int CRC_MAX_WIDTH = 64;
  localparam int CRC_MAX_DATA  = 1024;
  localparam int CRC_IDX_W     = $clog2(CRC_MAX_WIDTH);
  localparam int DATA_IDX_W    = $clog2(CRC_MAX_DATA);

  // One beat worth of LFSR steps: bit data_width-1 of data enters first.
  // The implicit x^crc_width term of the polynomial is not stored in poly.
  function automatic logic [CRC_MAX_WIDTH-1:0] crc_step(
    input logic [CRC_MAX_WIDTH-1:0] crc,
    input logic [CRC_MAX_DATA-1:0]  data,
    input logic [CRC_MAX_WIDTH-1:0] poly,
    input int                       data_width,
    input int                       crc_width
  );
    logic [CRC_MAX_WIDTH-1:0] mask;
    logic [CRC_MAX_WIDTH-1:0] acc;
    logic                     fb;
    mask = (crc_width >= CRC_MAX_WIDTH) ? '1 :
           ((CRC_MAX_WIDTH'(1) << crc_width) - CRC_MAX_WIDTH'(1));
    acc  = crc & mask;
    for (int i = CRC_MAX_DATA - 1; i >= 0; i--) begin
      if (i < data_width) begin
        fb  = acc[CRC_IDX_W'(crc_width - 1)] ^ data[DATA_IDX_W'(i)];
        acc = (acc << 1) & mask;
        if (fb) begin
          acc = acc ^ (poly & mask);
        end
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/crc_update.sv
// crc_update: combinational single-beat CRC advance. Thin wrapper around
// crc_pkg::crc_step so the checker and the matching generator share one
// implementation of the polynomial arithmetic.
module crc_update import crc_pkg::*; #(
  parameter int                   DATA_WIDTH = 512,
  parameter int                   CRC_WIDTH  = 32,
  parameter logic [CRC_WIDTH-1:0] POLY       = CRC_WIDTH'(32'h04C1_1DB7)
) (
  input  logic [CRC_WIDTH-1:0]  crc_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CRC_WIDTH-1:0]  crc_o
);

  assign crc_o = CRC_WIDTH'(crc_step(CRC_MAX_WIDTH'(crc_i),
                                     CRC_MAX_DATA'(data_i),
                                     CRC_MAX_WIDTH'(POLY),
                                     DATA_WIDTH,
                                     CRC_WIDTH));

endmodule

// File: rtl/crc_stream_checker.sv
// crc_stream_checker: multi-beat CRC check on a valid/ready packet stream.
// Each accepted beat advances a running CRC; the last beat's result is
// compared with checksum_i and the verdict rides out on that beat through a
// single output register. Packets longer than MAX_BEATS are cut at beat
// MAX_BEATS (flagged as overrun) and the remainder is swallowed.
// Optional feature: define CRC_ERR_CNT_EN to build the saturating count of
// flagged packets on err_cnt_o; otherwise err_cnt_o is tied to zero.
module crc_stream_checker import crc_pkg::*; #(
  parameter int                   DATA_WIDTH = 512,
  parameter int                   CRC_WIDTH  = 32,
  parameter logic [CRC_WIDTH-1:0] POLY       = CRC_WIDTH'(32'h04C1_1DB7),
  parameter logic [CRC_WIDTH-1:0] INIT       = '0,
  parameter int                   MAX_BEATS  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic [CRC_WIDTH-1:0]  checksum_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic                  detected_o,
  output logic                  overrun_o,
  output logic [15:0]           err_cnt_o
);

  localparam int               CNT_W    = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BEATS - 1);

  state_e                  state_q, state_d;
  logic [CRC_WIDTH-1:0]    crc_q, crc_d;
  logic [CRC_WIDTH-1:0]    crc_next;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    last_q, last_d;
  logic                    det_q, det_d;
  logic                    ovr_q, ovr_d;

  logic                    in_discard;
  logic                    accept;
  logic                    at_limit;
  logic                    overrun;
  logic                    pkt_end;

  assign in_discard = (state_q == DISCARD);
  assign ready_o    = in_discard || !valid_q || ready_i;
  assign accept     = valid_i && ready_o;
  assign at_limit   = (cnt_q == LAST_IDX);
  assign overrun    = !in_discard && at_limit && !last_i;
  assign pkt_end    = last_i || overrun;

  crc_update #(
    .DATA_WIDTH (DATA_WIDTH),
    .CRC_WIDTH  (CRC_WIDTH),
    .POLY       (POLY)
  ) u_crc_update (
    .crc_i  (crc_q),
    .data_i (data_i),
    .crc_o  (crc_next)
  );

  // Next state for the packet FSM, running CRC, beat count and output stage.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    det_d   = det_q;
    ovr_d   = ovr_q;

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      unique case (state_q)
        IDLE, BUSY: begin
          valid_d = 1'b1;
          data_d  = data_i;
          last_d  = pkt_end;
          ovr_d   = overrun;
          det_d   = overrun || (last_i && (crc_next != checksum_i));
          if (pkt_end) begin
            crc_d   = INIT;
            cnt_d   = '0;
            state_d = overrun ? DISCARD : IDLE;
          end else begin
            crc_d   = crc_next;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = BUSY;
          end
        end
        DISCARD: begin
          if (last_i) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, CRC and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      det_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      det_q   <= det_d;
      ovr_q   <= ovr_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign last_o     = last_q;
  assign detected_o = det_q;
  assign overrun_o  = ovr_q;

`ifdef CRC_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Count flagged packets as their last beat leaves, holding at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (valid_q && ready_i && last_q && det_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Error counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_crc_stream_checker.sv
// tb_crc_stream_checker: self-checking bench for crc_stream_checker in a
// CRC-8 configuration (8-bit beats, poly 0x07, init 0, MAX_BEATS 12).
// Expected CRCs come from polynomial long division of the packet bits.
module tb_crc_stream_checker;

  localparam int         MAX_BEATS = 12;
  localparam logic [7:0] POLY8     = 8'h07;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       det;
    logic       ovr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  data_i;
  logic        last_i;
  logic [7:0]  checksum_i;
  logic        valid_o;
  logic        ready_i;
  logic [7:0]  data_o;
  logic        last_o;
  logic        detected_o;
  logic        overrun_o;
  logic [15:0] err_cnt_o;

  int          vecCnt  = 0;
  int          missCnt = 0;
  int          expErr  = 0;
  exp_t        sb[$];
  logic [7:0]  pkt[$];
  logic [7:0]  goodCrc;

  bit          prevStall = 0;
  logic [11:0] prevOut;

  crc_stream_checker #(
    .DATA_WIDTH (8),
    .CRC_WIDTH  (8),
    .POLY       (POLY8),
    .INIT       (8'h00),
    .MAX_BEATS  (MAX_BEATS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_i     (data_i),
    .last_i     (last_i),
    .checksum_i (checksum_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .last_o     (last_o),
    .detected_o (detected_o),
    .overrun_o  (overrun_o),
    .err_cnt_o  (err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remainder of M(x) * x^8 divided by x^8 + POLY8, i.e. unreflected CRC-8.
  function automatic logic [7:0] refCrc(input logic [7:0] bytes[$]);
    bit         msg[$];
    logic [8:0] divisor;
    logic [7:0] rem;
    divisor = {1'b1, POLY8};
    foreach (bytes[b]) begin
      for (int k = 7; k >= 0; k--) msg.push_back(bytes[b][k]);
    end
    for (int k = 0; k < 8; k++) msg.push_back(1'b0);
    for (int i = 0; i + 8 < msg.size(); i++) begin
      if (msg[i]) begin
        for (int j = 0; j <= 8; j++) msg[i+j] = msg[i+j] ^ divisor[8-j];
      end
    end
    for (int k = 0; k < 8; k++) rem[7-k] = msg[msg.size()-8+k];
    return rem;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecCnt++;
    assert (got === exp) else begin
      missCnt++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one beat and hold it until the DUT accepts it (bounded).
  task automatic applyStimulus(input logic [7:0] d, input logic l, input logic [7:0] c,
                               input bit randReady, input int expReady);
    bit acc;
    int waitCnt;
    acc     = 1'b0;
    waitCnt = 0;
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    checksum_i = c;
    while (!acc && waitCnt < 200) begin
      if (randReady) ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (expReady >= 0 && waitCnt == 0) checkOutput("discard_ready_o", {63'd0, ready_o}, 64'(expReady));
      acc = ready_o;
      @(posedge clk);
      #1;
      waitCnt++;
    end
    if (!acc) checkOutput("accept_timeout", {63'd0, acc}, 64'd1);
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  // Queue the expected output beats of a packet, then send all its beats.
  task automatic sendPacket(input logic [7:0] p[$], input logic [7:0] cks, input bit randReady,
                            input int stallAt, input bit checkDiscard);
    int         n;
    int         shown;
    bit         over;
    logic [7:0] crc;
    logic [7:0] c;
    exp_t       e;
    n     = p.size();
    over  = (n > MAX_BEATS);
    shown = over ? MAX_BEATS : n;
    crc   = refCrc(p);
    for (int i = 0; i < shown; i++) begin
      e.data = p[i];
      e.last = (i == shown - 1);
      e.ovr  = over && e.last;
      e.det  = e.ovr || (e.last && (crc != cks));
      sb.push_back(e);
    end
    if (!randReady) ready_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      c = (i == n - 1) ? cks : 8'($urandom);
      if (i == stallAt) begin
        ready_i    = 1'b0;
        valid_i    = 1'b1;
        data_i     = p[i];
        last_i     = (i == n - 1);
        checksum_i = c;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checkOutput("stall_ready_o", {63'd0, ready_o}, 64'd0);
          @(posedge clk);
          #1;
        end
        ready_i = 1'b1;
      end
      if (checkDiscard && i >= MAX_BEATS) ready_i = 1'b0;
      applyStimulus(p[i], (i == n - 1), c, randReady,
                    (checkDiscard && i >= MAX_BEATS) ? 1 : -1);
    end
    ready_i = 1'b1;
  endtask

  task automatic drain();
    int guard;
    guard   = 0;
    ready_i = 1'b1;
    while (sb.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    checkOutput("drain_empty", {63'd0, (sb.size() == 0)}, 64'd1);
    checkOutput("idle_valid_o", {63'd0, valid_o}, 64'd0);
  endtask

  task automatic checkErrCnt(input string tag);
`ifdef CRC_ERR_CNT_EN
    checkOutput(tag, {48'd0, err_cnt_o}, 64'(expErr));
`else
    checkOutput(tag, {48'd0, err_cnt_o}, 64'd0);
`endif
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_valid_o", {63'd0, valid_o}, 64'd0);
    checkOutput("rst_data_o", {56'd0, data_o}, 64'd0);
    checkOutput("rst_last_o", {63'd0, last_o}, 64'd0);
    checkOutput("rst_detected_o", {63'd0, detected_o}, 64'd0);
    checkOutput("rst_overrun_o", {63'd0, overrun_o}, 64'd0);
    checkOutput("rst_err_cnt_o", {48'd0, err_cnt_o}, 64'd0);
  endtask

  task automatic randPacket(input int n);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
  endtask

  // Output monitor: scoreboard compare on each handshake, hold check on stalls.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stall_hold", {52'd0, valid_o, data_o, last_o, detected_o, overrun_o},
                    {52'd0, prevOut});
      end
      if (valid_o && ready_i) begin
        checkOutput("unexpected_beat", {63'd0, (sb.size() != 0)}, 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("data_o", {56'd0, data_o}, {56'd0, e.data});
          checkOutput("last_o", {63'd0, last_o}, {63'd0, e.last});
          checkOutput("detected_o", {63'd0, detected_o}, {63'd0, e.det});
          checkOutput("overrun_o", {63'd0, overrun_o}, {63'd0, e.ovr});
          if (e.last && e.det && expErr < 16'hFFFF) expErr++;
        end
        prevStall = 1'b0;
      end else if (valid_o) begin
        prevStall = 1'b1;
        prevOut   = {valid_o, data_o, last_o, detected_o, overrun_o};
      end else begin
        prevStall = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    valid_i    = 1'b0;
    data_i     = 8'h00;
    last_i     = 1'b0;
    checksum_i = 8'h00;
    ready_i    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkResetOutputs();
    rst_n = 1'b1;

    $display("[TB] CRC-8 of 123456789, good and bad checksum");
    pkt.delete();
    for (int k = 0; k < 9; k++) pkt.push_back(8'(8'h31 + k));
    sendPacket(pkt, 8'hF4, 1'b0, -1, 1'b0);
    sendPacket(pkt, 8'hF5, 1'b0, -1, 1'b0);
    drain();
    checkErrCnt("err_cnt_after_bad");

    $display("[TB] back-to-back single-beat packets");
    pkt.delete();
    pkt.push_back(8'h01);
    sendPacket(pkt, 8'h07, 1'b0, -1, 1'b0);
    checkOutput("latency_valid_o", {63'd0, valid_o}, 64'd1);
    checkOutput("latency_last_o", {63'd0, last_o}, 64'd1);
    checkOutput("latency_detected_o", {63'd0, detected_o}, 64'd0);
    sendPacket(pkt, 8'h07, 1'b0, -1, 1'b0);
    drain();

    $display("[TB] exactly MAX_BEATS beats");
    randPacket(MAX_BEATS);
    goodCrc = refCrc(pkt);
    sendPacket(pkt, goodCrc, 1'b0, -1, 1'b0);

    $display("[TB] over-long packet, then a normal one");
    randPacket(MAX_BEATS + 2);
    sendPacket(pkt, 8'($urandom), 1'b0, -1, 1'b1);
    randPacket(5);
    goodCrc = refCrc(pkt);
    sendPacket(pkt, goodCrc, 1'b0, -1, 1'b0);
    drain();
    checkErrCnt("err_cnt_after_overrun");

    $display("[TB] backpressure mid-packet");
    randPacket(6);
    goodCrc = refCrc(pkt);
    sendPacket(pkt, goodCrc, 1'b0, 3, 1'b0);
    drain();

    $display("[TB] reset mid-packet");
    randPacket(3);
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{data: pkt[i], last: 1'b0, det: 1'b0, ovr: 1'b0});
    end
    for (int i = 0; i < 3; i++) applyStimulus(pkt[i], 1'b0, 8'($urandom), 1'b0, -1);
    rst_n = 1'b0;
    sb.delete();
    expErr = 0;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs();
    rst_n = 1'b1;
    pkt.delete();
    for (int k = 0; k < 9; k++) pkt.push_back(8'(8'h31 + k));
    sendPacket(pkt, 8'hF4, 1'b0, -1, 1'b0);
    drain();

    $display("[TB] random packets with random backpressure");
    for (int p = 0; p < 20; p++) begin
      randPacket($urandom_range(1, MAX_BEATS + 3));
      goodCrc = refCrc(pkt);
      if ($urandom_range(0, 1) == 0) begin
        sendPacket(pkt, goodCrc, 1'b1, -1, 1'b0);
      end else begin
        sendPacket(pkt, goodCrc ^ 8'($urandom_range(1, 255)), 1'b1, -1, 1'b0);
      end
    end
    drain();
    checkErrCnt("err_cnt_final");

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule
